// File: rtl/logic_reduce.sv
// Registered bitwise reduction unit: folds a valid/ready burst of operands with AND/OR/XOR/NOR
// and holds the result, zero flag and saturating beat count until the consumer accepts it.
module logic_reduce #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_zero_q, out_zero_d;
  logic             accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = in_data;
          op_d    = op;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
          // NOR accumulates as OR; the inversion is applied on the output side.
          case (op_q)
            2'b00:   acc_d = acc_q & in_data;
            2'b10:   acc_d = acc_q ^ in_data;
            default: acc_d = acc_q | in_data;
          endcase
          if (cnt_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (in_last) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    out_data_d  = (op_d == 2'b11) ? ~acc_d : acc_d;
    out_zero_d  = (out_data_d == '0);
    in_ready_d  = (state_d != StHold);
    out_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      op_q        <= 2'b00;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_logic_reduce.sv
// Scoreboard bench for logic_reduce: the driver queues hand-computed results per burst and a
// negedge monitor pops and compares on every completed output handshake.
module tb_logic_reduce;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    op = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  logic_reduce #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    logic          zero;
    logic [CW-1:0] cnt;
    logic          ovf;
    int            hold;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [31:0] d, input logic z, input logic [CW-1:0] c,
                            input logic o, input int h);
    exp_t e;
    e.data = d; e.zero = z; e.cnt = c; e.ovf = o; e.hold = h;
    sb.push_back(e);
  endtask

  task automatic beat(input logic [1:0] o, input logic [31:0] d, input logic l);
    int n = 0;
    op = o; in_data = d; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  out_data,       32'd0);
    chk({tag, "_out_zero"},  32'(out_zero),  32'd1);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
    chk({tag, "_out_ovf"},   32'(out_ovf),   32'd0);
  endtask

  // Monitor: checks stability and in_ready during HOLD, compares on each accepted result.
  initial begin
    int            hold = 0;
    logic [31:0]   snap_data;
    logic [CW-1:0] snap_cnt;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
      end else if (out_valid === 1'b1) begin
        if (hold == 0) begin
          snap_data = out_data;
          snap_cnt  = out_count;
        end else begin
          chk("hold_data_stable",  out_data,       snap_data);
          chk("hold_count_stable", 32'(out_count), 32'(snap_cnt));
        end
        hold++;
        chk("in_ready_in_hold", 32'(in_ready), 32'd0);
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_result: got data 0x%08h, expected no result", out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data",  out_data,       e.data);
            chk("out_zero",  32'(out_zero),  32'(e.zero));
            chk("out_count", 32'(out_count), 32'(e.cnt));
            chk("out_ovf",   32'(out_ovf),   32'(e.ovf));
            chk("hold_cycles", 32'(hold),    32'(e.hold));
          end
          hold = 0;
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("por");
    @(posedge clk); #1;

    // OR burst with consumer back-pressure for three cycles
    out_ready = 1'b0;
    expect_res(32'h0F00_00F1, 1'b0, 2'd3, 1'b0, 4);
    beat(2'b01, 32'h0000_00F0, 1'b0);
    beat(2'b01, 32'h0F00_0000, 1'b0);
    beat(2'b01, 32'h0000_0001, 1'b1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;

    expect_res(32'h00FF_0000, 1'b0, 2'd2, 1'b0, 1);
    beat(2'b00, 32'hFFFF_0000, 1'b0);
    beat(2'b00, 32'h00FF_FF00, 1'b1);

    expect_res(32'h0000_0000, 1'b1, 2'd2, 1'b0, 1);
    beat(2'b10, 32'hAAAA_AAAA, 1'b0);
    beat(2'b10, 32'hAAAA_AAAA, 1'b1);

    expect_res(32'hFFFF_FFFF, 1'b0, 2'd1, 1'b0, 1);
    beat(2'b11, 32'h0000_0000, 1'b1);

    // op changes mid-burst and must be ignored
    expect_res(32'hFFFF_FFFC, 1'b0, 2'd2, 1'b0, 1);
    beat(2'b11, 32'h0000_0001, 1'b0);
    beat(2'b00, 32'h0000_0002, 1'b1);

    // XOR burst stalled mid-way
    expect_res(32'h0000_00FF, 1'b0, 2'd2, 1'b0, 1);
    beat(2'b10, 32'h0000_000F, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    beat(2'b01, 32'h0000_00F0, 1'b1);

    // counter reaches all-ones without overflow
    expect_res(32'h0000_0001, 1'b0, 2'd3, 1'b0, 1);
    for (int i = 0; i < 3; i++) beat(2'b01, 32'h1, (i == 2));

    // first increment attempted at all-ones
    expect_res(32'h0000_0001, 1'b0, 2'd3, 1'b1, 1);
    for (int i = 0; i < 4; i++) beat(2'b01, 32'h1, (i == 3));

    expect_res(32'h0000_001F, 1'b0, 2'd3, 1'b1, 1);
    for (int i = 0; i < 5; i++) beat(2'b01, 32'h1 << i, (i == 4));
    drain();
    @(posedge clk); #1;

    // reset aborts a burst in progress
    beat(2'b01, 32'h0000_0010, 1'b0);
    beat(2'b01, 32'h0000_0020, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("mid_rst");
    repeat (3) @(posedge clk);
    #1;

    expect_res(32'h0000_0005, 1'b0, 2'd1, 1'b0, 1);
    beat(2'b01, 32'h0000_0005, 1'b1);
    drain();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
